// File: rtl/miriscv_bus_pkg.sv
// Shared constants, decode target enum and byte-lane helper for the data bus slave.
package miriscv_bus_pkg;

    localparam logic [31:0] RAM_BASE_DEF  = 32'h0000_0000;
    localparam logic [31:0] MMIO_BASE_DEF = 32'h8000_0000;

    localparam logic [11:0] OFF_LED   = 12'h000;
    localparam logic [11:0] OFF_SW    = 12'h004;
    localparam logic [11:0] OFF_TCNT  = 12'h008;
    localparam logic [11:0] OFF_TCMP  = 12'h00C;
    localparam logic [11:0] OFF_TCTRL = 12'h010;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_PEND   = 2;

    typedef enum logic [1:0] {
        TGT_RAM,
        TGT_MMIO,
        TGT_NONE
    } tgt_e;

    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/miriscv_timer.sv
// Compare-match timer: free-running counter that clears on CMP match and latches a pending flag.
module miriscv_timer
    import miriscv_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst_i,
    input  logic        wr_cnt,
    input  logic        wr_cmp,
    input  logic        wr_ctrl,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] cnt,
    output logic [31:0] cmp,
    output logic [2:0]  ctrl,
    output logic        irq_o
);

    logic match;

    assign match = ctrl[CTRL_EN] && (cnt == cmp);

    always_ff @(posedge clk) begin
        if (rst_i) begin
            cnt  <= '0;
            cmp  <= '1;
            ctrl <= '0;
        end else begin
            // A software write to CNT overrides both the increment and the match clear.
            if (wr_cnt) begin
                cnt <= be_merge(cnt, wdata, be);
            end else if (ctrl[CTRL_EN]) begin
                cnt <= match ? 32'd0 : cnt + 32'd1;
            end

            if (wr_cmp) begin
                cmp <= be_merge(cmp, wdata, be);
            end

            if (wr_ctrl && be[0]) begin
                ctrl[CTRL_EN]     <= wdata[CTRL_EN];
                ctrl[CTRL_IRQ_EN] <= wdata[CTRL_IRQ_EN];
            end

            // A match in the same cycle as a W1C keeps the flag set.
            if (match) begin
                ctrl[CTRL_PEND] <= 1'b1;
            end else if (wr_ctrl && be[0] && wdata[CTRL_PEND]) begin
                ctrl[CTRL_PEND] <= 1'b0;
            end
        end
    end

    assign irq_o = ctrl[CTRL_PEND] & ctrl[CTRL_IRQ_EN];

endmodule

// File: rtl/miriscv_data_bus.sv
// Data-side slave: decodes LSU requests onto a byte-enabled RAM or the MMIO block, with a
// registered read path giving a fixed one-cycle read latency.
module miriscv_data_bus
    import miriscv_bus_pkg::*;
#(
    parameter int          RAM_WORDS = 1024,
    parameter logic [31:0] RAM_BASE  = RAM_BASE_DEF,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    input  logic [15:0] sw_i,
    output logic [15:0] led_o,
    output logic        irq_o,
    output logic        bus_err_o
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

    logic [31:0] mem [RAM_WORDS];

    logic [31:0]   ram_off;
    logic [AW-1:0] ram_idx;
    logic [11:0]   mmio_off;
    tgt_e          tgt;
    logic          ram_wr;
    logic          mmio_wr;
    logic [31:0]   mmio_rdata;

    logic [15:0] sw_meta;
    logic [15:0] sw_sync;

    logic [31:0] tmr_cnt;
    logic [31:0] tmr_cmp;
    logic [2:0]  tmr_ctrl;

    // Offset-based compare so an address below the base wraps to a large offset and misses.
    assign ram_off  = data_addr_i - RAM_BASE;
    assign ram_idx  = ram_off[AW+1:2];
    assign mmio_off = data_addr_i[11:0];

    always_comb begin
        tgt = TGT_NONE;
        if ({1'b0, ram_off} < RAM_BYTES) begin
            tgt = TGT_RAM;
        end else if (data_addr_i[31:12] == MMIO_BASE[31:12]) begin
            tgt = TGT_MMIO;
        end
    end

    assign ram_wr  = data_req_i && data_we_i && (tgt == TGT_RAM) && !rst_i;
    assign mmio_wr = data_req_i && data_we_i && (tgt == TGT_MMIO);

    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_be_i[i]) begin
                    mem[ram_idx][8*i +: 8] <= data_wdata_i[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        mmio_rdata = 32'h0;
        case (mmio_off)
            OFF_LED:   mmio_rdata = {16'h0, led_o};
            OFF_SW:    mmio_rdata = {16'h0, sw_sync};
            OFF_TCNT:  mmio_rdata = tmr_cnt;
            OFF_TCMP:  mmio_rdata = tmr_cmp;
            OFF_TCTRL: mmio_rdata = {29'h0, tmr_ctrl};
            default:   mmio_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            data_rdata_o <= '0;
            led_o        <= '0;
            bus_err_o    <= 1'b0;
            sw_meta      <= '0;
            sw_sync      <= '0;
        end else begin
            sw_meta   <= sw_i;
            sw_sync   <= sw_meta;
            bus_err_o <= data_req_i && (tgt == TGT_NONE);

            if (data_req_i && !data_we_i) begin
                case (tgt)
                    TGT_RAM:  data_rdata_o <= mem[ram_idx];
                    TGT_MMIO: data_rdata_o <= mmio_rdata;
                    default:  data_rdata_o <= 32'h0;
                endcase
            end

            if (mmio_wr && (mmio_off == OFF_LED)) begin
                if (data_be_i[0]) led_o[7:0]  <= data_wdata_i[7:0];
                if (data_be_i[1]) led_o[15:8] <= data_wdata_i[15:8];
            end
        end
    end

    miriscv_timer u_timer (
        .clk    (clk),
        .rst_i  (rst_i),
        .wr_cnt (mmio_wr && (mmio_off == OFF_TCNT)),
        .wr_cmp (mmio_wr && (mmio_off == OFF_TCMP)),
        .wr_ctrl(mmio_wr && (mmio_off == OFF_TCTRL)),
        .be     (data_be_i),
        .wdata  (data_wdata_i),
        .cnt    (tmr_cnt),
        .cmp    (tmr_cmp),
        .ctrl   (tmr_ctrl),
        .irq_o  (irq_o)
    );

endmodule

// File: tb/tb_miriscv_data_bus.sv
// Self-checking bench for miriscv_data_bus: vector table plus timer, switch and reset sequences.
module tb_miriscv_data_bus;

    logic        clk;
    logic        rst_i;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic [15:0] sw_i;
    logic [15:0] led_o;
    logic        irq_o;
    logic        bus_err_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [15:0] exp_led;
    } vec_t;

    vec_t        tbl[$];
    logic [32:0] sb_q[$];

    miriscv_data_bus dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .data_req_i  (data_req_i),
        .data_we_i   (data_we_i),
        .data_be_i   (data_be_i),
        .data_addr_i (data_addr_i),
        .data_wdata_i(data_wdata_i),
        .data_rdata_o(data_rdata_o),
        .sw_i        (sw_i),
        .led_o       (led_o),
        .irq_o       (irq_o),
        .bus_err_o   (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t vt(input logic req, input logic we, input logic [3:0] be,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rd, input logic err, input logic [15:0] led);
        vec_t v;
        v.req = req; v.we = we; v.be = be; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = rd; v.exp_err = err; v.exp_led = led;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives one bus cycle, pushes the expected response, then pops and compares after the edge.
    task automatic access(input string name, input logic req, input logic we,
                          input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] er, input logic ee);
        logic [32:0] exp;
        data_req_i   = req;
        data_we_i    = we;
        data_be_i    = be;
        data_addr_i  = addr;
        data_wdata_i = wdata;
        sb_q.push_back({er, ee});
        @(posedge clk);
        #1;
        data_req_i = 1'b0;
        data_we_i  = 1'b0;
        data_be_i  = 4'h0;
        if (sb_q.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            exp = sb_q.pop_front();
            chk({name, "_rdata"}, data_rdata_o, exp[32:1]);
            chk({name, "_err"}, {31'd0, bus_err_o}, {31'd0, exp[0]});
        end
    endtask

    initial begin
        rst_i        = 1'b1;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = 4'h0;
        data_addr_i  = 32'h0;
        data_wdata_i = 32'h0;
        sw_i         = 16'h00F0;

        tbl.push_back(vt(1, 1, 4'hF, 32'h0000_0010, 32'h1122_3344, 32'h0,         0, 16'h0));
        tbl.push_back(vt(1, 1, 4'h2, 32'h0000_0010, 32'h0000_AA00, 32'h0,         0, 16'h0));
        tbl.push_back(vt(1, 0, 4'h0, 32'h0000_0010, 32'h0,         32'h1122_AA44, 0, 16'h0));
        tbl.push_back(vt(0, 0, 4'h0, 32'h0,         32'h0,         32'h1122_AA44, 0, 16'h0));
        tbl.push_back(vt(1, 1, 4'hF, 32'h0000_0014, 32'hDEAD_BEEF, 32'h1122_AA44, 0, 16'h0));
        tbl.push_back(vt(0, 0, 4'h0, 32'h0,         32'h0,         32'h1122_AA44, 0, 16'h0));
        tbl.push_back(vt(0, 0, 4'h0, 32'h0,         32'h0,         32'h1122_AA44, 0, 16'h0));
        tbl.push_back(vt(1, 1, 4'h0, 32'h0000_0014, 32'hFFFF_FFFF, 32'h1122_AA44, 0, 16'h0));
        tbl.push_back(vt(1, 0, 4'hF, 32'h0000_0014, 32'h0,         32'hDEAD_BEEF, 0, 16'h0));
        tbl.push_back(vt(1, 1, 4'hF, 32'h0000_0FFC, 32'hCAFE_F00D, 32'hDEAD_BEEF, 0, 16'h0));
        tbl.push_back(vt(1, 0, 4'h0, 32'h0000_0FFC, 32'h0,         32'hCAFE_F00D, 0, 16'h0));
        tbl.push_back(vt(1, 0, 4'h0, 32'h0000_1000, 32'h0,         32'h0,         1, 16'h0));
        tbl.push_back(vt(0, 0, 4'h0, 32'h0,         32'h0,         32'h0,         0, 16'h0));
        tbl.push_back(vt(1, 1, 4'hF, 32'h8000_0000, 32'hFFFF_5A5A, 32'h0,         0, 16'h5A5A));
        tbl.push_back(vt(1, 0, 4'h0, 32'h8000_0000, 32'h0,         32'h0000_5A5A, 0, 16'h5A5A));
        tbl.push_back(vt(1, 1, 4'hF, 32'h8000_0004, 32'hFFFF_FFFF, 32'h0000_5A5A, 0, 16'h5A5A));
        tbl.push_back(vt(1, 0, 4'h0, 32'h8000_0004, 32'h0,         32'h0000_00F0, 0, 16'h5A5A));
        tbl.push_back(vt(1, 0, 4'h0, 32'h4000_0000, 32'h0,         32'h0,         1, 16'h5A5A));
        tbl.push_back(vt(0, 0, 4'h0, 32'h0,         32'h0,         32'h0,         0, 16'h5A5A));
        tbl.push_back(vt(1, 1, 4'hF, 32'h4000_0000, 32'hFFFF_FFFF, 32'h0,         1, 16'h5A5A));
        tbl.push_back(vt(1, 0, 4'h0, 32'h0000_0010, 32'h0,         32'h1122_AA44, 0, 16'h5A5A));
        tbl.push_back(vt(1, 0, 4'h0, 32'h8000_0000, 32'h0,         32'h0000_5A5A, 0, 16'h5A5A));
        tbl.push_back(vt(1, 0, 4'h0, 32'h8000_0020, 32'h0,         32'h0,         0, 16'h5A5A));
        tbl.push_back(vt(1, 1, 4'h1, 32'h8000_0000, 32'h0000_11C3, 32'h0,         0, 16'h5AC3));
        tbl.push_back(vt(1, 1, 4'h1, 32'h8000_0000, 32'h0000_005A, 32'h0,         0, 16'h5A5A));

        repeat (2) @(posedge clk);
        #1;
        chk("reset_rdata", data_rdata_o, 32'h0);
        chk("reset_led", {16'h0, led_o}, 32'h0);
        chk("reset_irq", {31'd0, irq_o}, 32'h0);
        chk("reset_err", {31'd0, bus_err_o}, 32'h0);
        rst_i = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            access($sformatf("vec%0d", i), tbl[i].req, tbl[i].we, tbl[i].be, tbl[i].addr,
                   tbl[i].wdata, tbl[i].exp_rdata, tbl[i].exp_err);
            chk($sformatf("vec%0d_led", i), {16'h0, led_o}, {16'h0, tbl[i].exp_led});
        end

        // Timer: CMP=3, enable with IRQ, then read CNT each cycle across the match.
        access("tcmp_wr",  1, 1, 4'hF, 32'h8000_000C, 32'd3, 32'h0, 0);
        access("tctrl_wr", 1, 1, 4'hF, 32'h8000_0010, 32'd3, 32'h0, 0);
        access("tcnt_rd0", 1, 0, 4'h0, 32'h8000_0008, 32'h0, 32'd0, 0);
        chk("irq_c0", {31'd0, irq_o}, 32'd0);
        access("tcnt_rd1", 1, 0, 4'h0, 32'h8000_0008, 32'h0, 32'd1, 0);
        chk("irq_c1", {31'd0, irq_o}, 32'd0);
        access("tcnt_rd2", 1, 0, 4'h0, 32'h8000_0008, 32'h0, 32'd2, 0);
        chk("irq_c2", {31'd0, irq_o}, 32'd0);
        access("tcnt_rd3", 1, 0, 4'h0, 32'h8000_0008, 32'h0, 32'd3, 0);
        chk("irq_match", {31'd0, irq_o}, 32'd1);
        access("tcnt_rd4", 1, 0, 4'h0, 32'h8000_0008, 32'h0, 32'd0, 0);
        chk("irq_hold", {31'd0, irq_o}, 32'd1);
        access("w1c", 1, 1, 4'hF, 32'h8000_0010, 32'd7, 32'd0, 0);
        chk("irq_w1c", {31'd0, irq_o}, 32'd0);
        access("idle_cnt3", 0, 0, 4'h0, 32'h0, 32'h0, 32'd0, 0);
        access("w1c_match", 1, 1, 4'hF, 32'h8000_0010, 32'd7, 32'd0, 0);
        chk("irq_set_wins", {31'd0, irq_o}, 32'd1);
        access("tctrl_rd", 1, 0, 4'h0, 32'h8000_0010, 32'h0, 32'd7, 0);
        access("tcnt_wr", 1, 1, 4'hF, 32'h8000_0008, 32'h10, 32'd7, 0);
        access("tcnt_rd_wr", 1, 0, 4'h0, 32'h8000_0008, 32'h0, 32'h10, 0);

        // Switch synchroniser: new value visible to a read two cycles after the change.
        sw_i = 16'h0F0F;
        access("sw_rd_early", 1, 0, 4'h0, 32'h8000_0004, 32'h0, 32'h0000_00F0, 0);
        access("sw_idle", 0, 0, 4'h0, 32'h0, 32'h0, 32'h0000_00F0, 0);
        access("sw_rd_late", 1, 0, 4'h0, 32'h8000_0004, 32'h0, 32'h0000_0F0F, 0);

        // Reset in the middle of a read with the timer running and LEDs lit.
        chk("pre_rst_irq", {31'd0, irq_o}, 32'd1);
        chk("pre_rst_led", {16'h0, led_o}, 32'h0000_5A5A);
        rst_i       = 1'b1;
        data_req_i  = 1'b1;
        data_we_i   = 1'b0;
        data_addr_i = 32'h0000_0010;
        @(posedge clk);
        #1;
        rst_i      = 1'b0;
        data_req_i = 1'b0;
        chk("rst_rdata", data_rdata_o, 32'h0);
        chk("rst_led", {16'h0, led_o}, 32'h0);
        chk("rst_irq", {31'd0, irq_o}, 32'h0);
        chk("rst_err", {31'd0, bus_err_o}, 32'h0);
        access("rst_tcnt", 1, 0, 4'h0, 32'h8000_0008, 32'h0, 32'h0, 0);
        access("rst_tcmp", 1, 0, 4'h0, 32'h8000_000C, 32'h0, 32'hFFFF_FFFF, 0);
        access("rst_ram",  1, 0, 4'h0, 32'h0000_0010, 32'h0, 32'h1122_AA44, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
